// File: rtl/branch_pkg.sv
// Shared definitions for the branch prediction controller: resolve-op
// encodings, the counter reset value and the conditional-op classifier.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_JUMP = 3'd3,
        BR_LTZ  = 3'd4,
        BR_GEZ  = 3'd5
    } br_op_e;

    // Weakly not-taken: the value just below the taken/not-taken midpoint.
    function automatic int unsigned ctr_reset_val(input int unsigned ctr_w);
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

    // Conditional branches are the only ops that train the predictor.
    function automatic logic is_conditional(input logic [2:0] op);
        return (op == BR_EQ) || (op == BR_NE) || (op == BR_LTZ) || (op == BR_GEZ);
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Table of saturating direction counters. One combinational read port with
// write-first bypass (a read of the entry being written this cycle returns
// the post-update value) and one saturating increment/decrement write port.
module sat_counter_table
    import branch_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int CTR_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic [CTR_W-1:0]   rd_ctr,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic               wr_taken
);

    localparam int DEPTH = 1 << INDEX_W;
    localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_reset_val(CTR_W));
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] c, input logic up);
        if (up) begin
            return (c == CTR_MAX) ? c : c + CTR_W'(1);
        end
        return (c == '0) ? c : c - CTR_W'(1);
    endfunction

    logic [CTR_W-1:0] ctr_q [DEPTH];
    logic [CTR_W-1:0] ctr_d [DEPTH];
    logic [CTR_W-1:0] wr_val;

    // Post-update value of the entry addressed by the write port.
    always_comb begin
        wr_val = sat_step(ctr_q[wr_index], wr_taken);
    end

    // Next-state of the whole array: only the written entry changes.
    always_comb begin
        ctr_d = ctr_q;
        if (wr_en) begin
            ctr_d[wr_index] = wr_val;
        end
    end

    // Read port with write-first bypass.
    always_comb begin
        rd_ctr = (wr_en && (wr_index == rd_index)) ? wr_val : ctr_q[rd_index];
    end

    // Counter storage; reset puts every entry at weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_RST;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch resolve / predict controller. Resolves EX-stage branch outcomes,
// predicts conditional branches at fetch from a saturating-counter table,
// and raises a registered one-cycle mispredict pulse for flush logic.
// Optional build macro BRANCH_PREDICT_GSHARE_EN: XOR a non-speculative
// global history register into the lookup index (gshare).
module branch_predict_ctrl
    import branch_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int PC_W    = 32,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lookup_valid,
    input  logic [PC_W-1:0]    lookup_pc,
    output logic               pred_valid,
    output logic               pred_taken,
    output logic [INDEX_W-1:0] pred_index,
    input  logic               res_valid,
    input  logic [2:0]         res_op,
    input  logic               res_alu_zero,
    input  logic               res_alu_neg,
    input  logic [INDEX_W-1:0] res_index,
    input  logic               res_pred_taken,
    output logic               branch,
    output logic               mispredict,
    input  logic               stat_clr,
    output logic [STAT_W-1:0]  stat_branches,
    output logic [STAT_W-1:0]  stat_mispredicts
);

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

    logic [INDEX_W-1:0] pc_index;
    logic [INDEX_W-1:0] lookup_index;
    logic [CTR_W-1:0]   rd_ctr;
    logic               cond_res;
    logic               resolves_flow;

    logic               pred_valid_q, pred_valid_d;
    logic               pred_taken_q, pred_taken_d;
    logic [INDEX_W-1:0] pred_index_q, pred_index_d;
    logic               mispredict_q, mispredict_d;
    logic [STAT_W-1:0]  stat_br_q, stat_br_d;
    logic [STAT_W-1:0]  stat_mp_q, stat_mp_d;

    // PC bits outside the index field do not affect prediction.
    logic unused_pc;
    assign unused_pc = ^{lookup_pc[PC_W-1:INDEX_W+2], lookup_pc[1:0]};

    assign pc_index = lookup_pc[INDEX_W+1:2];

`ifdef BRANCH_PREDICT_GSHARE_EN
    logic [INDEX_W-1:0] ghr_q, ghr_d;

    // History shifts in the actual outcome of each conditional resolve.
    always_comb begin
        ghr_d = cond_res ? {ghr_q[INDEX_W-2:0], branch} : ghr_q;
    end

    // Global history register, updated on the same edge as the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign lookup_index = pc_index ^ ghr_q;
`else
    assign lookup_index = pc_index;
`endif

    // Actual outcome of the instruction presented by EX.
    always_comb begin
        branch = 1'b0;
        if (res_valid) begin
            case (res_op)
                BR_EQ:   branch = res_alu_zero;
                BR_NE:   branch = !res_alu_zero;
                BR_JUMP: branch = 1'b1;
                BR_LTZ:  branch = res_alu_neg;
                BR_GEZ:  branch = !res_alu_neg;
                default: branch = 1'b0;
            endcase
        end
    end

    assign cond_res      = res_valid && is_conditional(res_op);
    assign resolves_flow = cond_res || (res_valid && (res_op == BR_JUMP));

    sat_counter_table #(
        .INDEX_W (INDEX_W),
        .CTR_W   (CTR_W)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (lookup_index),
        .rd_ctr   (rd_ctr),
        .wr_en    (cond_res),
        .wr_index (res_index),
        .wr_taken (branch)
    );

    // Next-state for prediction, mispredict pulse and statistics.
    always_comb begin
        pred_valid_d = lookup_valid;
        pred_taken_d = lookup_valid ? rd_ctr[CTR_W-1] : pred_taken_q;
        pred_index_d = lookup_valid ? lookup_index : pred_index_q;
        mispredict_d = resolves_flow && (branch != res_pred_taken);

        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (stat_clr) begin
            stat_br_d = '0;
            stat_mp_d = '0;
        end else if (cond_res) begin
            stat_br_d = sat_inc(stat_br_q);
            if (branch != res_pred_taken) begin
                stat_mp_d = sat_inc(stat_mp_q);
            end
        end
    end

    // Registered outputs; reset drops any pending mispredict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_index_q <= '0;
            mispredict_q <= 1'b0;
            stat_br_q    <= '0;
            stat_mp_q    <= '0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_index_q <= pred_index_d;
            mispredict_q <= mispredict_d;
            stat_br_q    <= stat_br_d;
            stat_mp_q    <= stat_mp_d;
        end
    end

    assign pred_valid       = pred_valid_q;
    assign pred_taken       = pred_taken_q;
    assign pred_index       = pred_index_q;
    assign mispredict       = mispredict_q;
    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl (narrow stats so saturation is reachable).
module tb_branch_predict_ctrl;

    localparam int IW = 6;
    localparam int PW = 32;
    localparam int CW = 2;
    localparam int SW = 2;
    localparam int NE = 1 << IW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lookup_valid = 1'b0;
    logic [PW-1:0] lookup_pc = '0;
    logic          pred_valid;
    logic          pred_taken;
    logic [IW-1:0] pred_index;
    logic          res_valid = 1'b0;
    logic [2:0]    res_op = '0;
    logic          res_alu_zero = 1'b0;
    logic          res_alu_neg = 1'b0;
    logic [IW-1:0] res_index = '0;
    logic          res_pred_taken = 1'b0;
    logic          branch;
    logic          mispredict;
    logic          stat_clr = 1'b0;
    logic [SW-1:0] stat_branches;
    logic [SW-1:0] stat_mispredicts;

    branch_predict_ctrl #(
        .INDEX_W (IW),
        .PC_W    (PW),
        .CTR_W   (CW),
        .STAT_W  (SW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .pred_index       (pred_index),
        .res_valid        (res_valid),
        .res_op           (res_op),
        .res_alu_zero     (res_alu_zero),
        .res_alu_neg      (res_alu_neg),
        .res_index        (res_index),
        .res_pred_taken   (res_pred_taken),
        .branch           (branch),
        .mispredict       (mispredict),
        .stat_clr         (stat_clr),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model state
    logic [CW-1:0] mdl_ctr [NE];
    logic [SW-1:0] mdl_br;
    logic [SW-1:0] mdl_mp;
    logic [IW-1:0] mdl_ghr;

    // Scoreboard queues
    logic          exp_misp_q [$];
    logic [IW:0]   exp_pred_q [$];

    task automatic model_reset();
        for (int i = 0; i < NE; i++) mdl_ctr[i] = CW'((1 << (CW - 1)) - 1);
        mdl_br  = '0;
        mdl_mp  = '0;
        mdl_ghr = '0;
        exp_misp_q.delete();
        exp_pred_q.delete();
    endtask

    task automatic cycle(input logic lv, input logic [31:0] pc, input logic rv,
                         input logic [2:0] op, input logic z, input logic ng,
                         input logic [IW-1:0] idx, input logic pt, input logic clr);
        logic          act;
        logic          cond;
        logic          misp;
        logic [IW-1:0] li;
        logic [IW:0]   ep;
        logic          em;
        @(negedge clk);
        lookup_valid = lv; lookup_pc = pc;
        res_valid = rv; res_op = op; res_alu_zero = z; res_alu_neg = ng;
        res_index = idx; res_pred_taken = pt; stat_clr = clr;
        act = 1'b0;
        if (rv) begin
            case (op)
                3'd1: act = z;
                3'd2: act = !z;
                3'd3: act = 1'b1;
                3'd4: act = ng;
                3'd5: act = !ng;
                default: act = 1'b0;
            endcase
        end
        cond = rv && (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5);
        misp = (cond || (rv && op == 3'd3)) && (act != pt);
        #1;
        check("branch", 32'(branch), 32'(act));
        exp_misp_q.push_back(misp);
        li = pc[IW+1:2];
`ifdef BRANCH_PREDICT_GSHARE_EN
        li = li ^ mdl_ghr;
`endif
        if (cond) begin
            if (act && mdl_ctr[idx] != '1) mdl_ctr[idx] = mdl_ctr[idx] + CW'(1);
            if (!act && mdl_ctr[idx] != '0) mdl_ctr[idx] = mdl_ctr[idx] - CW'(1);
            mdl_ghr = {mdl_ghr[IW-2:0], act};
        end
        if (lv) exp_pred_q.push_back({mdl_ctr[li][CW-1], li});
        if (clr) begin
            mdl_br = '0;
            mdl_mp = '0;
        end else if (cond) begin
            if (mdl_br != '1) mdl_br = mdl_br + SW'(1);
            if (misp && mdl_mp != '1) mdl_mp = mdl_mp + SW'(1);
        end
        @(posedge clk);
        #1;
        em = exp_misp_q.pop_front();
        check("mispredict", 32'(mispredict), 32'(em));
        check("pred_valid", 32'(pred_valid), 32'(lv));
        if (lv) begin
            ep = exp_pred_q.pop_front();
            check("pred_taken", 32'(pred_taken), 32'(ep[IW]));
            check("pred_index", 32'(pred_index), 32'(ep[IW-1:0]));
        end
        check("stat_branches", 32'(stat_branches), 32'(mdl_br));
        check("stat_mispredicts", 32'(stat_mispredicts), 32'(mdl_mp));
    endtask

    initial begin
        model_reset();
        #12;
        check("rst pred_valid", 32'(pred_valid), 32'd0);
        check("rst pred_taken", 32'(pred_taken), 32'd0);
        check("rst pred_index", 32'(pred_index), 32'd0);
        check("rst mispredict", 32'(mispredict), 32'd0);
        check("rst stat_br", 32'(stat_branches), 32'd0);
        check("rst stat_mp", 32'(stat_mispredicts), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Initial lookup of 0x40: weakly not-taken, index 16
        cycle(1, 32'h40, 0, 3'd0, 0, 0, 6'd0, 0, 0);
        // Four taken beq on index 16 predicted not-taken; stats saturate at 3
        for (int i = 0; i < 4; i++) cycle(0, 32'h0, 1, 3'd1, 1, 0, 6'd16, 0, 0);
        // Trained entry now predicts taken
        cycle(1, 32'h40, 0, 3'd0, 0, 0, 6'd0, 0, 0);
        // Clear wins over a simultaneous conditional mispredict
        cycle(0, 32'h0, 1, 3'd2, 0, 0, 6'd16, 0, 1);
        // Jump predicted not-taken: mispredict, no stats, no training
        cycle(0, 32'h0, 1, 3'd3, 0, 0, 6'd20, 0, 0);
        cycle(1, 32'h50, 0, 3'd0, 0, 0, 6'd0, 0, 0);
        // bltz taken, predicted taken
        cycle(0, 32'h0, 1, 3'd4, 0, 1, 6'd3, 1, 0);
        // Same-cycle lookup and update on index 5 (bypass)
        cycle(1, 32'h14, 1, 3'd1, 1, 0, 6'd5, 0, 0);
        // bgez taken predicted not-taken; not-taken beq predicted taken
        cycle(0, 32'h0, 1, 3'd5, 0, 0, 6'd7, 0, 0);
        cycle(0, 32'h0, 1, 3'd1, 0, 0, 6'd8, 1, 0);
        // Reserved and none ops never branch or mispredict
        cycle(0, 32'h0, 1, 3'd6, 1, 1, 6'd9, 1, 0);
        cycle(0, 32'h0, 1, 3'd0, 1, 1, 6'd9, 1, 0);
        // Saturate down at zero then look up
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 1, 3'd2, 1, 0, 6'd9, 0, 1);
        cycle(1, 32'h24, 0, 3'd0, 0, 0, 6'd0, 0, 0);
        // Random traffic
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), IW'($urandom_range(0, NE - 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        // Reset arriving with a mispredicting resolve in flight
        @(negedge clk);
        lookup_valid = 1'b0; stat_clr = 1'b0;
        res_valid = 1'b1; res_op = 3'd1; res_alu_zero = 1'b1;
        res_index = 6'd16; res_pred_taken = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst mispredict", 32'(mispredict), 32'd0);
        check("midrst stat_br", 32'(stat_branches), 32'd0);
        @(negedge clk);
        res_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        cycle(1, 32'h40, 0, 3'd0, 0, 0, 6'd0, 0, 0);
        cycle(1, 32'h14, 0, 3'd0, 0, 0, 6'd0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
